// File: rtl/e_mdu.sv
// e_mdu: Execute-stage multiply/divide unit.
// Owns HI/LO, runs MULT/MULTU/DIV/DIVU as fixed-latency operations
// (result computed at launch, committed after the latency expires),
// and serves MTHI/MTLO/MFHI/MFLO.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        start,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e      r_state;
    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    logic        w_is_mult;
    logic        w_is_div;
    logic        w_signed;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div_zero;

    // Operation decode and the launch-time result (multiply or divide).
    // Signed divide is done on magnitudes so INT_MIN / -1 wraps cleanly
    // to INT_MIN with remainder 0 instead of overflowing.
    always_comb begin
        w_is_mult  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        w_is_div   = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
        w_signed   = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
        start      = w_is_mult || w_is_div;

        w_mul_a    = w_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
        w_mul_b    = w_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
        w_prod     = w_mul_a * w_mul_b;

        w_a_neg    = w_signed && src_a[31];
        w_b_neg    = w_signed && src_b[31];
        w_a_mag    = w_a_neg ? (32'd0 - src_a) : src_a;
        w_b_mag    = w_b_neg ? (32'd0 - src_b) : src_b;
        w_div_zero = (src_b == '0);
        w_q_mag    = w_div_zero ? '0 : (w_a_mag / w_b_mag);
        w_r_mag    = w_div_zero ? '0 : (w_a_mag % w_b_mag);

        if (w_is_mult) begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end else begin
            w_res_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
            w_res_hi = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        end
    end

    // Read mux for MFHI/MFLO; zero for every other op.
    always_comb begin
        mdu_out = '0;
        case (mdu_op)
            OP_MFHI: mdu_out = r_hi;
            OP_MFLO: mdu_out = r_lo;
            default: mdu_out = '0;
        endcase
    end

    // Launch/run/commit FSM plus MTHI/MTLO writes while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_wr <= !(w_is_div && w_div_zero);
                        r_cnt     <= w_is_mult ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end else if (mdu_op == OP_MTHI) begin
                        r_hi <= src_a;
                    end else if (mdu_op == OP_MTLO) begin
                        r_lo <= src_a;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and randomized checks of e_mdu against a
// timestamp-based reference model using 64-bit integer arithmetic.
module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        start;
    logic        busy;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .mdu_op  (mdu_op),
        .src_a   (src_a),
        .src_b   (src_b),
        .start   (start),
        .busy    (busy),
        .mdu_out (mdu_out),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: an operation launched at edge E commits at edge E+N.
    int          edge_no   = 0;
    bit          m_active  = 0;
    int          m_done_at = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] m_phi = '0, m_plo = '0;
    bit          m_pwr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_result(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] rh,
                                       output logic [31:0] rl, output bit wr);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = '0; rl = '0; wr = 1;
        case (op)
            4'd1: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
            4'd3: begin
                if (b == 0) wr = 0;
                else begin
                    q = sa / sb; r = sa % sb;
                    p = q; rl = p[31:0];
                    p = r; rh = p[31:0];
                end
            end
            default: begin
                if (b == 0) wr = 0;
                else begin rl = a / b; rh = a % b; end
            end
        endcase
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model, clock, check state.
    task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rst);
        logic [31:0] exp_out;
        mdu_op = op; src_a = a; src_b = b; reset = rst;
        #1;
        chk("start", {31'd0, start}, {31'd0, (op >= 1 && op <= 4)});
        exp_out = (op == 7) ? m_hi : (op == 8) ? m_lo : '0;
        chk("mdu_out", mdu_out, exp_out);
        edge_no++;
        if (rst) begin
            m_active = 0; m_hi = '0; m_lo = '0;
        end else if (m_active) begin
            if (edge_no == m_done_at) begin
                m_active = 0;
                if (m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
            end
        end else if (op >= 1 && op <= 4) begin
            ref_result(op, a, b, m_phi, m_plo, m_pwr);
            m_active  = 1;
            m_done_at = edge_no + ((op <= 2) ? MULT_N : DIV_N);
        end else if (op == 5) begin
            m_hi = a;
        end else if (op == 6) begin
            m_lo = a;
        end
        @(posedge clk);
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    // Launch one op, then idle until busy drops (bounded); report busy length.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int nb);
        cycle(op, a, b, 1'b0);
        nb = 0;
        while (busy && nb < 64) begin
            nb++;
            cycle(4'd0, $urandom, $urandom, 1'b0);
        end
    endtask

    initial begin
        int nb;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        mdu_op = '0; src_a = '0; src_b = '0; reset = 1'b1;

        cycle(4'd0, '0, '0, 1'b1);
        cycle(4'd0, '0, '0, 1'b1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        launch(4'd1, 32'hFFFFFFFD, 32'd5, nb);
        chk("mult_len", nb, MULT_N);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);

        launch(4'd2, 32'hFFFFFFFF, 32'd2, nb);
        chk("multu_len", nb, MULT_N);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        launch(4'd3, 32'hFFFFFFF9, 32'd2, nb);
        chk("div_len", nb, DIV_N);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        launch(4'd3, 32'h80000000, 32'hFFFFFFFF, nb);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h00000000);

        cycle(4'd5, 32'h11, '0, 1'b0);
        cycle(4'd6, 32'h22, '0, 1'b0);
        launch(4'd4, 32'd1000, 32'd0, nb);
        chk("dz_len", nb, DIV_N);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        // Restart and operand change while busy must not relaunch.
        cycle(4'd1, 32'd7, 32'd6, 1'b0);
        cycle(4'd3, 32'd100, 32'd3, 1'b0);
        nb = 1;
        while (busy && nb < 64) begin
            nb++;
            cycle(4'd1, $urandom, $urandom, 1'b0);
        end
        chk("relaunch_len", nb, MULT_N);
        chk("relaunch_hi", hi, 32'd0);
        chk("relaunch_lo", lo, 32'd42);

        cycle(4'd6, 32'h1234, '0, 1'b0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", lo, 32'h1234);
        mdu_op = 4'd8;
        #1;
        chk("mflo_out", mdu_out, 32'h1234);

        cycle(4'd2, 32'd3, 32'd3, 1'b0);
        cycle(4'd5, 32'hDEAD, '0, 1'b0);
        chk("mthi_busy_hi", hi, 32'd0);
        launch(4'd0, '0, '0, nb);
        chk("mthi_busy_final", hi, 32'd0);

        // Reset during the fourth busy cycle of a DIV aborts it.
        cycle(4'd3, 32'd100, 32'd7, 1'b0);
        cycle(4'd0, '0, '0, 1'b0);
        cycle(4'd0, '0, '0, 1'b0);
        cycle(4'd0, '0, '0, 1'b0);
        cycle(4'd0, '0, '0, 1'b1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) cycle(4'd0, '0, '0, 1'b0);
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        for (int i = 0; i < 600; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            cycle(rop, ra, rb, ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit of the Execute stage in the 5-stage MIPS pipeline. Sits alongside the ALU and consumes the D/E pipeline-register outputs (forwarded rs/rt values plus the decoded MDU op).
- Owns the HI/LO registers and runs multi-cycle MULT/MULTU/DIV/DIVU. Serves MTHI/MTLO/MFHI/MFLO.
- Drives `busy` to the hazard unit, which stalls D while an MDU instruction is pending.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for MULT/MULTU (legal range 1..31).
- DIV_CYCLES, 10, cycles `busy` stays high for DIV/DIVU (legal range 1..31).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mdu_op  input  4  decoded E-stage op:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO.
  - 9..15 are treated as NONE.
- src_a  input  32  forwarded rs value (E_GRF_rs).
- src_b  input  32  forwarded rt value (E_GRF_rt).
- start  output  1  combinational; high when mdu_op is 1..4.
- busy  output  1  registered; operation in progress.
- mdu_out  output  32  combinational read result: HI for MFHI, LO for MFLO, else 0.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (sync, active-high) sets busy=0, hi=0, lo=0, internal counter=0 and pending-result registers=0.
  - Reset asserted mid-operation aborts it: HI/LO are not updated.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter = remaining cycles).
- Launch, at an edge in IDLE with start=1:
  - Compute the result from src_a/src_b; operands are captured at launch, so later input changes are irrelevant.
  - Hold the result in pending registers.
  - Go to busy=1, counter = MULT_CYCLES or DIV_CYCLES.
- RUN:
  - Each edge decrements the counter.
  - At the edge where counter==1: busy<=0, hi/lo <= pending result, return to IDLE.
  - Net effect: busy is high for exactly N cycles after the launch edge, and new HI/LO is visible in the first cycle busy reads 0.
- start while busy=1 is ignored: no relaunch, no change to counter. The hazard unit guarantees this never occurs legally; the bench must still check it.
- MULT: {hi,lo} = signed(src_a) * signed(src_b), full 64-bit product.
- MULTU: same as MULT, unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Division by zero (src_b==0, DIV or DIVU):
  - Still runs DIV_CYCLES with busy high.
  - HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - When busy=0: hi (or lo) <= src_a at the edge; no busy.
  - When busy=1: ignored.
- MFHI/MFLO:
  - mdu_out reflects the current hi/lo combinationally.
  - Reading while busy=1 returns the old value; stalling these is the hazard unit's job.
- Stall condition the hazard unit builds: (start | busy) and the D-stage instruction is any MDU op.
  - This block drives only start/busy.
- The E/M pipeline register captures mdu_out for MF* writeback.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5:
  - start=1 for one cycle; busy high exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - hi/lo keep their old values during busy.
- MULTU src_a=0xFFFFFFFF, src_b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV cases:
  - src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero and mid-op input change:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO.
  - DIVU with src_b=0 -> busy 10 cycles, then hi=0x11, lo=0x22.
  - A MULT launched, then a second start plus operand change during busy -> the first result only, no relaunch.
- Idle vs busy writes and reads:
  - MTLO src_a=0x1234 while idle -> lo=0x1234 next cycle, busy stays 0.
  - MTHI while busy -> hi unchanged.
  - MFLO -> mdu_out=0x1234 same cycle.
- Reset mid-operation:
  - Launch DIV, assert reset at busy cycle 4.
  - Next cycle busy=0, hi=lo=0, and no later HI/LO update occurs.
